// File: rtl/risc_pkg.sv
// Shared definitions for the single-cycle MIPS-subset core: datapath widths,
// opcode/funct encodings, ALU control enum, decoded control bundle and the
// immediate sign-extend helper.
package risc_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned RAW   = 5;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } alu_ctrl_e;

  typedef struct packed {
    logic      regwrite;
    logic      regdst;
    logic      alusrc;
    logic      memwrite;
    logic      memtoreg;
    logic      branch;
    logic      jump;
    alu_ctrl_e alucontrol;
  } ctrl_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
    return {{(XLEN-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/risc_processor_core_dpath.sv
// Datapath of the single-cycle core and its storage blocks.
//   risc_regfile : 32 x 32 register file, 2 async read ports, 1 sync write port,
//                  register 0 hard-wired to zero.
//     clk, reset, we, ra1, ra2, wa, wd -> rd1, rd2
//   risc_dmem    : word-addressed data RAM, async read, sync write.
//     clk, reset, we, addr, wd -> rd
//   risc_dpath   : PC, instruction ROM, sign-extend, ALU, muxes; hosts rbank/dmem.
//     clk, reset, ctrl (decoded control) -> op, funct (to decoder), writedata

module risc_regfile
  import risc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [RAW-1:0]  ra1,
  input  logic [RAW-1:0]  ra2,
  input  logic [RAW-1:0]  wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  // Initialiser gives the all-zero state at time 0 even if reset never asserts.
  logic [XLEN-1:0] regfile [0:NREGS-1] = '{default: '0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regfile[i] <= '0;
    end else if (we && (wa != '0)) begin
      regfile[wa] <= wd;
    end
  end

  assign rd1 = regfile[ra1];
  assign rd2 = regfile[ra2];

endmodule

module risc_dmem
  import risc_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd
);

  logic [XLEN-1:0] dmem [0:DEPTH-1] = '{default: '0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) dmem[i] <= '0;
    end else if (we) begin
      dmem[addr] <= wd;
    end
  end

  assign rd = dmem[addr];

endmodule

module risc_dpath
  import risc_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64,
  parameter string       IMEM_FILE  = "prog.hex"
) (
  input  logic            clk,
  input  logic            reset,
  input  ctrl_t           ctrl,
  output logic [5:0]      op,
  output logic [5:0]      funct,
  output logic [XLEN-1:0] writedata
);

  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);

  logic [XLEN-1:0] pc = '0;
  logic [XLEN-1:0] pcnext, pcplus4, pcbranch, pcjump;
  logic [XLEN-1:0] instr, signimm, srca, srcb, aluresult, readdata, result;
  logic [RAW-1:0]  writereg;
  logic            zero;

  // Unloaded ROM words stay zero, i.e. sll $0,$0,0, which decodes as a NOP.
  logic [XLEN-1:0] imem [0:IMEM_DEPTH-1] = '{default: '0};

  // Fetch ignores PC bits above the ROM index, so fetch wraps modulo IMEM_DEPTH.
  assign instr = imem[pc[IAW+1:2]];
  assign op    = instr[31:26];
  assign funct = instr[5:0];

  assign signimm  = sext16(instr[15:0]);
  assign pcplus4  = pc + 32'd4;
  assign pcbranch = pcplus4 + (signimm << 2);
  assign pcjump   = {pcplus4[31:28], instr[25:0], 2'b00};

  always_comb begin
    pcnext = pcplus4;
    if (ctrl.jump)                  pcnext = pcjump;
    else if (ctrl.branch && zero)   pcnext = pcbranch;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else       pc <= pcnext;
  end

  assign writereg = ctrl.regdst ? instr[15:11] : instr[20:16];

  risc_regfile rbank (
    .clk (clk),
    .reset (reset),
    .we  (ctrl.regwrite),
    .ra1 (instr[25:21]),
    .ra2 (instr[20:16]),
    .wa  (writereg),
    .wd  (result),
    .rd1 (srca),
    .rd2 (writedata)
  );

  assign srcb = ctrl.alusrc ? signimm : writedata;

  always_comb begin
    aluresult = '0;
    unique case (ctrl.alucontrol)
      ALU_AND: aluresult = srca & srcb;
      ALU_OR:  aluresult = srca | srcb;
      ALU_ADD: aluresult = srca + srcb;
      ALU_SUB: aluresult = srca - srcb;
      ALU_SLT: aluresult = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default: aluresult = '0;
    endcase
  end

  assign zero = (aluresult == '0);

  risc_dmem #(.DEPTH(DMEM_DEPTH)) dmem (
    .clk  (clk),
    .reset (reset),
    .we   (ctrl.memwrite),
    .addr (aluresult[DAW+1:2]),
    .wd   (writedata),
    .rd   (readdata)
  );

  assign result = ctrl.memtoreg ? readdata : aluresult;

endmodule

// File: rtl/risc_processor_core.sv
// Single-cycle 32-bit MIPS-subset CPU top: combinational control decoder plus
// the datapath instance "dpath" (PC, ROM, register file, ALU, data RAM).
// Ports:
//   clk       in   1  rising-edge clock
//   reset     in   1  asynchronous active-high; clears PC, registers, data RAM
//   writedata out 32  rt register value presented to data RAM (store data)
module risc_processor_core
  import risc_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64,
  parameter string       IMEM_FILE  = "prog.hex"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] writedata
);

  ctrl_t      ctrl;
  logic [5:0] op;
  logic [5:0] funct;

  // Unknown opcodes and unknown R-type functs leave every enable low: a NOP.
  always_comb begin
    ctrl            = '0;
    ctrl.alucontrol = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        ctrl.regdst = 1'b1;
        case (funct)
          FN_ADD: begin ctrl.regwrite = 1'b1; ctrl.alucontrol = ALU_ADD; end
          FN_SUB: begin ctrl.regwrite = 1'b1; ctrl.alucontrol = ALU_SUB; end
          FN_AND: begin ctrl.regwrite = 1'b1; ctrl.alucontrol = ALU_AND; end
          FN_OR:  begin ctrl.regwrite = 1'b1; ctrl.alucontrol = ALU_OR;  end
          FN_SLT: begin ctrl.regwrite = 1'b1; ctrl.alucontrol = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ADDI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      OP_SW: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch     = 1'b1;
        ctrl.alucontrol = ALU_SUB;
      end
      OP_J: ctrl.jump = 1'b1;
      default: ;
    endcase
  end

  risc_dpath #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .DMEM_DEPTH (DMEM_DEPTH),
    .IMEM_FILE  (IMEM_FILE)
  ) dpath (
    .clk       (clk),
    .reset     (reset),
    .ctrl      (ctrl),
    .op        (op),
    .funct     (funct),
    .writedata (writedata)
  );

endmodule

// File: tb/tb_risc_processor_core.sv
module tb_risc_processor_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] writedata;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog [0:63];

  risc_processor_core #(
    .IMEM_DEPTH (64),
    .DMEM_DEPTH (64),
    .IMEM_FILE  ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .writedata (writedata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] target);
    return {6'h02, target};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = '0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 64; i++) dut.dpath.imem[i] = prog[i];
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic prog_a();
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);     // addi $1,$0,5
    prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd12);    // addi $2,$0,12
    prog[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);      // add $3,$1,$2
    prog[3] = enc_r(5'd2, 5'd1, 5'd4, 6'h22);      // sub $4,$2,$1
    prog[4] = enc_i(6'h2B, 5'd0, 5'd3, 16'd0);     // sw $3,0($0)
    prog[5] = enc_i(6'h2B, 5'd0, 5'd4, 16'd4);     // sw $4,4($0)
    prog[6] = enc_i(6'h23, 5'd0, 5'd1, 16'd4);     // lw $1,4($0)
    prog[7] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);     // addi $0,$0,9
  endtask

  task automatic restart();
    reset = 1'b1;
    load_prog();
    step(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    prog_a();
    load_prog();
    #1;
    checks++;
    if (dut.dpath.pc !== 32'd0) begin
      errors++; $display("FAIL powerup_pc: got %0h expected 0", dut.dpath.pc);
    end
    for (int i = 0; i <= 4; i++) begin
      v = dut.dpath.rbank.regfile[i];
      checks++;
      if (v !== 32'd0) begin
        errors++; $display("FAIL powerup_reg%0d: got %0h expected 0", i, v);
      end
    end
    for (int i = 0; i <= 2; i++) begin
      v = dut.dpath.dmem.dmem[i];
      checks++;
      if (v !== 32'd0) begin
        errors++; $display("FAIL powerup_mem%0d: got %0h expected 0", i, v);
      end
    end
    checks++;
    if (writedata !== 32'd0) begin
      errors++; $display("FAIL powerup_writedata: got %0h expected 0", writedata);
    end
  endtask

  task automatic test_arith();
    logic [31:0] exp [1:4];
    logic [31:0] v;
    exp[1] = 32'd5; exp[2] = 32'd12; exp[3] = 32'd17; exp[4] = 32'd7;
    step(4);
    for (int i = 1; i <= 4; i++) begin
      v = dut.dpath.rbank.regfile[i];
      checks++;
      if (v !== exp[i]) begin
        errors++; $display("FAIL arith_reg%0d: got %0h expected %0h", i, v, exp[i]);
      end
    end
    checks++;
    if (dut.dpath.pc !== 32'd16) begin
      errors++; $display("FAIL arith_pc: got %0h expected 10", dut.dpath.pc);
    end
    checks++;
    if (writedata !== 32'd17) begin
      errors++; $display("FAIL sw_writedata: got %0h expected 11", writedata);
    end
  endtask

  task automatic test_mem();
    step(3);
    checks++;
    if (dut.dpath.dmem.dmem[0] !== 32'd17) begin
      errors++; $display("FAIL mem0: got %0h expected 11", dut.dpath.dmem.dmem[0]);
    end
    checks++;
    if (dut.dpath.dmem.dmem[1] !== 32'd7) begin
      errors++; $display("FAIL mem1: got %0h expected 7", dut.dpath.dmem.dmem[1]);
    end
    checks++;
    if (dut.dpath.dmem.dmem[2] !== 32'd0) begin
      errors++; $display("FAIL mem2_untouched: got %0h expected 0", dut.dpath.dmem.dmem[2]);
    end
    checks++;
    if (dut.dpath.rbank.regfile[1] !== 32'd7) begin
      errors++; $display("FAIL lw_reg1: got %0h expected 7", dut.dpath.rbank.regfile[1]);
    end
    step(1);
    checks++;
    if (dut.dpath.rbank.regfile[0] !== 32'd0) begin
      errors++; $display("FAIL reg0_write: got %0h expected 0", dut.dpath.rbank.regfile[0]);
    end
    checks++;
    if (dut.dpath.pc !== 32'd32) begin
      errors++; $display("FAIL mem_pc: got %0h expected 20", dut.dpath.pc);
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] exp [1:4];
    logic [31:0] v;
    exp[1] = 32'd7; exp[2] = 32'd12; exp[3] = 32'd17; exp[4] = 32'd7;
    reset = 1'b1;
    #1;
    checks++;
    if (dut.dpath.pc !== 32'd0) begin
      errors++; $display("FAIL midreset_pc: got %0h expected 0", dut.dpath.pc);
    end
    for (int i = 1; i <= 4; i++) begin
      v = dut.dpath.rbank.regfile[i];
      checks++;
      if (v !== 32'd0) begin
        errors++; $display("FAIL midreset_reg%0d: got %0h expected 0", i, v);
      end
    end
    for (int i = 0; i <= 1; i++) begin
      v = dut.dpath.dmem.dmem[i];
      checks++;
      if (v !== 32'd0) begin
        errors++; $display("FAIL midreset_mem%0d: got %0h expected 0", i, v);
      end
    end
    step(1);
    reset = 1'b0;
    step(8);
    for (int i = 1; i <= 4; i++) begin
      v = dut.dpath.rbank.regfile[i];
      checks++;
      if (v !== exp[i]) begin
        errors++; $display("FAIL rerun_reg%0d: got %0h expected %0h", i, v, exp[i]);
      end
    end
    checks++;
    if (dut.dpath.dmem.dmem[0] !== 32'd17 || dut.dpath.dmem.dmem[1] !== 32'd7) begin
      errors++;
      $display("FAIL rerun_mem: got %0h/%0h expected 11/7",
               dut.dpath.dmem.dmem[0], dut.dpath.dmem.dmem[1]);
    end
  endtask

  task automatic test_loop();
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);      // addi $1,$0,3
    prog[1] = enc_i(6'h08, 5'd1, 5'd1, 16'hFFFF);   // loop: addi $1,$1,-1
    prog[2] = enc_i(6'h04, 5'd1, 5'd0, 16'd1);      // beq $1,$0,done
    prog[3] = enc_j(26'd1);                         // j loop
    restart();
    step(3);
    checks++;
    if (dut.dpath.pc !== 32'd12 || dut.dpath.rbank.regfile[1] !== 32'd2) begin
      errors++;
      $display("FAIL beq_not_taken: got pc=%0h r1=%0h expected pc=c r1=2",
               dut.dpath.pc, dut.dpath.rbank.regfile[1]);
    end
    step(1);
    checks++;
    if (dut.dpath.pc !== 32'd4) begin
      errors++; $display("FAIL jump_target: got %0h expected 4", dut.dpath.pc);
    end
    step(5);
    checks++;
    if (dut.dpath.pc !== 32'd16) begin
      errors++; $display("FAIL loop_exit_pc: got %0h expected 10", dut.dpath.pc);
    end
    checks++;
    if (dut.dpath.rbank.regfile[1] !== 32'd0) begin
      errors++; $display("FAIL loop_reg1: got %0h expected 0", dut.dpath.rbank.regfile[1]);
    end
    step(1);
    checks++;
    if (dut.dpath.pc !== 32'd20) begin
      errors++; $display("FAIL after_done_pc: got %0h expected 14", dut.dpath.pc);
    end
  endtask

  task automatic test_misc();
    int          idx [0:8];
    logic [31:0] exp [0:8];
    logic [31:0] v;
    clear_prog();
    prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF);  // addi $1,$0,-1
    prog[1]  = enc_i(6'h08, 5'd0, 5'd3, 16'd2);     // addi $3,$0,2
    prog[2]  = enc_r(5'd1, 5'd3, 5'd2, 6'h2A);      // slt $2,$1,$3
    prog[3]  = enc_r(5'd3, 5'd1, 5'd5, 6'h2A);      // slt $5,$3,$1
    prog[4]  = enc_i(6'h08, 5'd0, 5'd6, 16'h000C);  // addi $6,$0,0xC
    prog[5]  = enc_i(6'h08, 5'd0, 5'd7, 16'h000A);  // addi $7,$0,0xA
    prog[6]  = enc_r(5'd6, 5'd7, 5'd8, 6'h24);      // and $8,$6,$7
    prog[7]  = enc_r(5'd6, 5'd7, 5'd9, 6'h25);      // or $9,$6,$7
    prog[8]  = enc_i(6'h08, 5'd0, 5'd0, 16'd9);     // addi $0,$0,9
    prog[9]  = enc_i(6'h3F, 5'd0, 5'd10, 16'd5);    // unknown opcode
    prog[10] = enc_r(5'd6, 5'd7, 5'd11, 6'h3F);     // unknown funct
    prog[11] = enc_i(6'h2B, 5'd0, 5'd6, 16'd256);   // sw $6,256($0) -> word 0
    prog[12] = enc_i(6'h23, 5'd0, 5'd14, 16'd0);    // lw $14,0($0)
    prog[13] = enc_r(5'd1, 5'd1, 5'd15, 6'h20);     // add $15,$1,$1
    restart();
    step(14);
    idx[0] = 0;  exp[0] = 32'h0;
    idx[1] = 1;  exp[1] = 32'hFFFF_FFFF;
    idx[2] = 2;  exp[2] = 32'h1;
    idx[3] = 5;  exp[3] = 32'h0;
    idx[4] = 8;  exp[4] = 32'h8;
    idx[5] = 9;  exp[5] = 32'hE;
    idx[6] = 10; exp[6] = 32'h0;
    idx[7] = 11; exp[7] = 32'h0;
    idx[8] = 14; exp[8] = 32'hC;
    for (int i = 0; i <= 8; i++) begin
      v = dut.dpath.rbank.regfile[idx[i]];
      checks++;
      if (v !== exp[i]) begin
        errors++; $display("FAIL misc_reg%0d: got %0h expected %0h", idx[i], v, exp[i]);
      end
    end
    checks++;
    if (dut.dpath.rbank.regfile[15] !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL add_neg_reg15: got %0h expected fffffffe", dut.dpath.rbank.regfile[15]);
    end
    checks++;
    if (dut.dpath.dmem.dmem[0] !== 32'hC) begin
      errors++; $display("FAIL dmem_wrap: got %0h expected c", dut.dpath.dmem.dmem[0]);
    end
    checks++;
    if (dut.dpath.pc !== 32'd56) begin
      errors++; $display("FAIL misc_pc: got %0h expected 38", dut.dpath.pc);
    end
    step(50);
    checks++;
    if (dut.dpath.pc !== 32'd256 || dut.dpath.instr !== prog[0]) begin
      errors++;
      $display("FAIL fetch_wrap: got pc=%0h instr=%0h expected pc=100 instr=%0h",
               dut.dpath.pc, dut.dpath.instr, prog[0]);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mem();
    test_reset_midrun();
    test_loop();
    test_misc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
